game_round_controller: RTL and testbench



---
 rtl/mastermind_pkg.sv | 32 +++
 rtl/code_shift_reg.sv | 41 ++++
 rtl/game_round_controller.sv | 134 +++++++++++++
 tb/tb_game_round_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind game: state encoding, winner codes,
// default code geometry and small score helpers.
package mastermind_pkg;

  localparam int unsigned SYM_W_DEF    = 3;
  localparam int unsigned CODE_LEN_DEF = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MAKE  = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_BREAK = 3'd3;
  localparam logic [2:0] ST_SCORE = 3'd4;
  localparam logic [2:0] ST_SWAP  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // 2-bit score increment that sticks at 3 instead of wrapping.
  function automatic logic [1:0] sat_inc(input logic [1:0] s);
    return (s == 2'd3) ? s : s + 2'd1;
  endfunction

  function automatic logic [1:0] pick_winner(input logic [1:0] a, input logic [1:0] b);
    if (a > b) return WIN_A;
    if (b > a) return WIN_B;
    return WIN_TIE;
  endfunction

endpackage

// File: rtl/code_shift_reg.sv
// Secret-code shift register: symbols enter at the LSB end so the first
// symbol entered ends up in the MSBs; counts symbols loaded so far.
module code_shift_reg
  import mastermind_pkg::*;
#(
  parameter int unsigned SYM_W    = SYM_W_DEF,
  parameter int unsigned CODE_LEN = CODE_LEN_DEF,
  localparam int unsigned CODE_W  = SYM_W * CODE_LEN,
  localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [SYM_W-1:0]  sym,
  output logic [CODE_W-1:0] code,
  output logic [CNT_W-1:0]  cnt,
  output logic              full
);

  logic [CODE_W-1:0] code_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      code_q <= '0;
      cnt_q  <= '0;
    end else if (load && !full) begin
      code_q <= {code_q[CODE_W-SYM_W-1:0], sym};
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign code = code_q;
  assign cnt  = cnt_q;
  assign full = (cnt_q == CNT_W'(CODE_LEN));

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer for the Mastermind game: collects the maker's code, launches
// the codebreaker, scores the verdict, swaps roles and detects game end.
module game_round_controller
  import mastermind_pkg::*;
#(
  parameter int unsigned SYM_W      = SYM_W_DEF,
  parameter int unsigned CODE_LEN   = CODE_LEN_DEF,
  parameter int unsigned MAX_ROUNDS = 4,
  parameter int unsigned WIN_POINTS = 3,
  localparam int unsigned CODE_W    = SYM_W * CODE_LEN,
  localparam int unsigned RND_W     = $clog2(MAX_ROUNDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              first_maker_b,
  input  logic              enterA,
  input  logic              enterB,
  input  logic [SYM_W-1:0]  SW,
  input  logic              break_done,
  input  logic              breaker_won,
  output logic [CODE_W-1:0] maker_code,
  output logic              code_valid,
  output logic              break_start,
  output logic              maker_is_a,
  output logic [1:0]        scoreA,
  output logic [1:0]        scoreB,
  output logic [RND_W-1:0]  round,
  output logic              game_over,
  output logic [1:0]        winner
);

  localparam int unsigned CNT_W = $clog2(CODE_LEN + 1);

  logic [2:0]       state_q, state_d;
  logic             maker_a_q;
  logic             won_q;
  logic [1:0]       score_a_q, score_b_q;
  logic [RND_W-1:0] round_q;

  logic             maker_enter, sr_load, sr_clear, sr_full;
  logic [CNT_W-1:0] sr_cnt;
  logic             a_gains;
  logic [1:0]       new_a, new_b;
  logic [RND_W-1:0] new_round;
  logic             game_end;

  // Only the current maker's enter button feeds the code register.
  assign maker_enter = maker_a_q ? enterA : enterB;
  assign sr_load     = (state_q == ST_MAKE) && maker_enter;
  assign sr_clear    = ((state_q == ST_IDLE) && start) || (state_q == ST_SWAP);

  code_shift_reg #(
    .SYM_W    (SYM_W),
    .CODE_LEN (CODE_LEN)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .clear (sr_clear),
    .load  (sr_load),
    .sym   (SW),
    .code  (maker_code),
    .cnt   (sr_cnt),
    .full  (sr_full)
  );

  // A scores when A broke the code, or when A was maker and the breaker failed.
  always_comb begin
    a_gains   = won_q ? ~maker_a_q : maker_a_q;
    new_a     = a_gains ? sat_inc(score_a_q) : score_a_q;
    new_b     = a_gains ? score_b_q : sat_inc(score_b_q);
    new_round = round_q + RND_W'(1);
    game_end  = (new_round == RND_W'(MAX_ROUNDS)) ||
                (new_a == 2'(WIN_POINTS)) || (new_b == 2'(WIN_POINTS));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_MAKE;
      ST_MAKE:  if (sr_load && !sr_full && (sr_cnt == CNT_W'(CODE_LEN - 1))) state_d = ST_ARM;
      ST_ARM:   state_d = ST_BREAK;
      ST_BREAK: if (break_done) state_d = ST_SCORE;
      ST_SCORE: state_d = game_end ? ST_DONE : ST_SWAP;
      ST_SWAP:  state_d = ST_MAKE;
      ST_DONE:  if (start) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maker_a_q <= 1'b0;
      won_q     <= 1'b0;
      score_a_q <= '0;
      score_b_q <= '0;
      round_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            maker_a_q <= ~first_maker_b;
            score_a_q <= '0;
            score_b_q <= '0;
            round_q   <= '0;
          end
        end
        ST_BREAK: if (break_done) won_q <= breaker_won;
        ST_SCORE: begin
          score_a_q <= new_a;
          score_b_q <= new_b;
          round_q   <= new_round;
        end
        ST_SWAP: maker_a_q <= ~maker_a_q;
        default: ;
      endcase
    end
  end

  assign code_valid  = (state_q == ST_ARM) || (state_q == ST_BREAK);
  assign break_start = (state_q == ST_ARM);
  assign maker_is_a  = maker_a_q;
  assign scoreA      = score_a_q;
  assign scoreB      = score_b_q;
  assign round       = round_q;
  assign game_over   = (state_q == ST_DONE);
  assign winner      = (state_q == ST_DONE) ? pick_winner(score_a_q, score_b_q) : WIN_NONE;

endmodule

// File: tb/tb_game_round_controller.sv
// Scoreboard bench for game_round_controller: stimulus pushes expected arm,
// score and game-end results; a negedge monitor pops and compares them.
module tb_game_round_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        first_maker_b = 1'b0;
  logic        enterA = 1'b0;
  logic        enterB = 1'b0;
  logic [2:0]  SW = '0;
  logic        break_done = 1'b0;
  logic        breaker_won = 1'b0;
  logic [11:0] maker_code;
  logic        code_valid, break_start, maker_is_a, game_over;
  logic [1:0]  scoreA, scoreB, winner;
  logic [2:0]  round;

  int checks = 0;
  int errors = 0;
  int bs_cnt = 0;

  logic [12:0] arm_q[$];    // {maker_is_a, code}
  logic [6:0]  score_q[$];  // {scoreA, scoreB, round}
  logic [1:0]  done_q[$];   // winner

  game_round_controller dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .first_maker_b (first_maker_b),
    .enterA        (enterA),
    .enterB        (enterB),
    .SW            (SW),
    .break_done    (break_done),
    .breaker_won   (breaker_won),
    .maker_code    (maker_code),
    .code_valid    (code_valid),
    .break_start   (break_start),
    .maker_is_a    (maker_is_a),
    .scoreA        (scoreA),
    .scoreB        (scoreB),
    .round         (round),
    .game_over     (game_over),
    .winner        (winner)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic ea, input logic eb, input logic [2:0] sw);
    enterA = ea;
    enterB = eb;
    SW     = sw;
    tick();
    enterA = 1'b0;
    enterB = 1'b0;
  endtask

  task automatic start_game(input logic fmb);
    first_maker_b = fmb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Enters symbols from index 'from' onwards; leaves the DUT in BREAK.
  task automatic make_code(input logic ma, input logic [11:0] code, input int from,
                           input logic pulse_in_arm);
    arm_q.push_back({ma, code});
    for (int i = from; i < 4; i++) enter(ma, ~ma, code[11-3*i -: 3]);
    if (pulse_in_arm) begin
      break_done  = 1'b1;
      breaker_won = 1'b1;
    end
    tick();
    break_done  = 1'b0;
    breaker_won = 1'b0;
  endtask

  task automatic verdict(input logic won, input logic [1:0] ea, input logic [1:0] eb,
                         input logic [2:0] er, input logic fin, input logic [1:0] ewin);
    score_q.push_back({ea, eb, er});
    if (fin) done_q.push_back(ewin);
    break_done  = 1'b1;
    breaker_won = won;
    tick();
    break_done  = 1'b0;
    breaker_won = 1'b0;
    tick();
    if (!fin) tick();
  endtask

  // Monitor: compare every visible output event against the queued expectations.
  logic [2:0] prev_round = '0;
  logic       prev_go = 1'b0;
  always @(negedge clk) begin
    if (break_start) begin
      bs_cnt++;
      if (arm_q.size() == 0) chk("unexpected_break_start", 1, 0);
      else begin
        logic [12:0] e;
        e = arm_q.pop_front();
        chk("arm_code", maker_code, e[11:0]);
        chk("arm_maker", maker_is_a, e[12]);
        chk("arm_code_valid", code_valid, 1);
      end
    end
    if (round != prev_round && round != 0) begin
      if (score_q.size() == 0) chk("unexpected_score", 1, 0);
      else begin
        logic [6:0] e;
        e = score_q.pop_front();
        chk("score_round", {scoreA, scoreB, round}, e);
      end
    end
    if (game_over && !prev_go) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("winner", winner, done_q.pop_front());
    end
    prev_round = round;
    prev_go    = game_over;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_state", dut.state_q, 0);
    chk("reset_outputs", {maker_code, code_valid, break_start, maker_is_a, scoreA, scoreB,
                          round, game_over, winner}, 0);

    // Abort a game mid-MAKE with an asynchronous reset.
    start_game(1'b0);
    enter(1, 0, 3'd1);
    enter(1, 0, 3'd2);
    chk("pre_reset_code", maker_code, 12'o0012);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_state", dut.state_q, 0);
    chk("mid_reset_code", maker_code, 0);
    chk("mid_reset_cnt", dut.u_shift.cnt_q, 0);
    chk("mid_reset_misc", {scoreA, scoreB, game_over, maker_is_a}, 0);
    tick();
    reset = 1'b0;

    // Game: B breaks round 1, B makes round 2, B breaks round 3 -> B reaches 3.
    start_game(1'b0);
    chk("maker_a_first", maker_is_a, 1);
    make_code(1, 12'o1234, 0, 1);
    chk("break_state_after_arm_pulse", dut.state_q, 3);
    chk("break_code_valid", code_valid, 1);
    enter(1, 0, 3'd6);
    chk("break_code_frozen", maker_code, 12'o1234);
    chk("arm_pulse_no_score", {scoreA, scoreB, round}, 0);
    verdict(1, 2'd0, 2'd1, 3'd1, 0, 2'b00);
    chk("swap_maker_b", maker_is_a, 0);
    chk("swap_code_clear", maker_code, 0);
    make_code(0, 12'o7654, 0, 0);
    verdict(0, 2'd0, 2'd2, 3'd2, 0, 2'b00);
    chk("swap_maker_a", maker_is_a, 1);
    enter(0, 1, 3'd7);
    enter(1, 1, 3'd5);
    chk("both_enter_cnt", dut.u_shift.cnt_q, 1);
    chk("both_enter_code", maker_code, 12'o0005);
    make_code(1, 12'o5123, 1, 0);
    verdict(1, 2'd0, 2'd3, 3'd3, 1, 2'b10);
    chk("done_game_over", game_over, 1);
    break_done = 1'b1;
    breaker_won = 1'b0;
    tick();
    break_done = 1'b0;
    chk("done_hold", {scoreA, scoreB, round, winner}, {2'd0, 2'd3, 3'd3, 2'b10});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_to_idle", dut.state_q, 0);
    chk("idle_no_game_over", {game_over, winner}, 0);

    // Game: B makes first, breaker wins every round -> 2-2 tie after 4 rounds.
    start_game(1'b1);
    make_code(0, 12'o0123, 0, 0);
    verdict(1, 2'd1, 2'd0, 3'd1, 0, 2'b00);
    make_code(1, 12'o4567, 0, 0);
    verdict(1, 2'd1, 2'd1, 3'd2, 0, 2'b00);
    make_code(0, 12'o7070, 0, 0);
    verdict(1, 2'd2, 2'd1, 3'd3, 0, 2'b00);
    make_code(1, 12'o3333, 0, 0);
    verdict(1, 2'd2, 2'd2, 3'd4, 1, 2'b11);
    chk("tie_round", round, 4);
    start_game(1'b0);

    // Game: A scores every round, then spare verdicts in DONE must not add points.
    start_game(1'b0);
    make_code(1, 12'o1111, 0, 0);
    verdict(0, 2'd1, 2'd0, 3'd1, 0, 2'b00);
    make_code(0, 12'o2222, 0, 0);
    verdict(1, 2'd2, 2'd0, 3'd2, 0, 2'b00);
    make_code(1, 12'o6543, 0, 0);
    verdict(0, 2'd3, 2'd0, 3'd3, 1, 2'b01);
    for (int i = 0; i < 2; i++) begin
      break_done = 1'b1;
      breaker_won = i[0];
      tick();
      break_done = 1'b0;
    end
    chk("stress_sat", {scoreA, scoreB, round}, {2'd3, 2'd0, 3'd3});

    repeat (3) tick();
    chk("arm_q_empty", arm_q.size(), 0);
    chk("score_q_empty", score_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("break_start_pulses", bs_cnt, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
